osc_ctrl: RTL and testbench

OSC_CTRL -- requirements
Module: osc_ctrl

---
 rtl/osc_ctrl.sv | 119 +++++++++++
 tb/tb_osc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_ctrl.sv
// osc_ctrl: host-command sequencer that loads, paces and retunes a resonator oscillator
module osc_ctrl #(
    parameter int unsigned TMO_CYC = 1048575
) (
    input  logic        Fg_clk,
    input  logic        Resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_mode,
    input  logic [31:0] cmd_init1,
    input  logic [31:0] cmd_init2,
    input  logic [15:0] cmd_rate_div,
    input  logic [31:0] osc_out1,
    output logic        Enable,
    output logic        Ready,
    output logic        FreqChng,
    output logic [2:0]  Mode,
    output logic [31:0] init1,
    output logic [31:0] init2,
    output logic        busy,
    output logic        err,
    output logic        upd_done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CHG, WAIT} state_t;
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_CHANGE = 2'd1;
    localparam logic [1:0] OP_STOP = 2'd2;
    localparam logic [19:0] TMO_LAST = 20'(TMO_CYC - 1);
    state_t state;
    logic [15:0] rate_div;
    logic [15:0] div_cnt;
    logic [15:0] div_nxt;
    logic [19:0] tmo_cnt;
    logic xfer;
    logic zc;
    logic tmo_hit;
    // handshake, zero-crossing window, divider wrap and apply/timeout detection
    always_comb begin
        cmd_ready = (state == IDLE) || (state == RUN);
        busy = !cmd_ready;
        xfer = cmd_valid && cmd_ready;
        zc = (Mode == 3'd4) ? (&osc_out1[31:23] || ~|osc_out1[31:23])
                            : (&osc_out1[31:22] || ~|osc_out1[31:22]);
        div_nxt = (div_cnt == rate_div) ? 16'd0 : div_cnt + 16'd1;
        upd_done = (state == WAIT) && Enable && zc;
        tmo_hit = tmo_cnt == TMO_LAST;
    end
    // control FSM; Enable is registered from the next divider value so it is glitch-free
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            Enable <= 1'b0;
            Ready <= 1'b0;
            FreqChng <= 1'b0;
            err <= 1'b0;
            Mode <= 3'd0;
            init1 <= 32'd0;
            init2 <= 32'd0;
            rate_div <= 16'd0;
            div_cnt <= 16'd0;
            tmo_cnt <= 20'd0;
        end else begin
            Ready <= 1'b0;
            FreqChng <= 1'b0;
            Enable <= 1'b0;
            if (xfer && cmd_op == OP_START) begin
                Mode <= cmd_mode;
                init1 <= cmd_init1;
                init2 <= cmd_init2;
                rate_div <= cmd_rate_div;
                err <= 1'b0;
                state <= LOAD;
                Ready <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        state <= RUN;
                        div_cnt <= 16'd0;
                        Enable <= rate_div == 16'd0;
                    end
                    RUN: begin
                        div_cnt <= div_nxt;
                        if (xfer && cmd_op == OP_STOP) begin
                            state <= IDLE;
                        end else if (xfer && cmd_op == OP_CHANGE) begin
                            init1 <= cmd_init1;
                            init2 <= cmd_init2;
                            state <= CHG;
                            FreqChng <= 1'b1;
                        end else begin
                            Enable <= div_nxt == rate_div;
                        end
                    end
                    CHG: begin
                        state <= WAIT;
                        tmo_cnt <= 20'd0;
                        Enable <= div_cnt == rate_div;
                    end
                    WAIT: begin
                        div_cnt <= div_nxt;
                        if (upd_done) begin
                            state <= RUN;
                            Enable <= div_nxt == rate_div;
                        end else if (tmo_hit) begin
                            err <= 1'b1;
                            state <= LOAD;
                            Ready <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 20'd1;
                            Enable <= div_nxt == rate_div;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_osc_ctrl.sv
// tb_osc_ctrl: directed and random stimulus on two osc_ctrl instances (short and long timeout) against a reference model
module tb_osc_ctrl;
    localparam int TMO_A = 15;
    localparam int TMO_B = 64;
    localparam int IDLE = 0, LOAD = 1, RUN = 2, CHG = 3, WAIT = 4;
    logic Fg_clk = 1'b0;
    logic Resetn = 1'b0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd3;
    logic [2:0] cmd_mode = 3'd0;
    logic [31:0] cmd_init1 = 32'd0;
    logic [31:0] cmd_init2 = 32'd0;
    logic [15:0] cmd_rate_div = 16'd0;
    logic [31:0] osc_out1 = 32'd0;
    logic cmd_ready [2];
    logic busy [2];
    logic en [2];
    logic rdy [2];
    logic fchg [2];
    logic err [2];
    logic upd [2];
    logic [2:0] mode_o [2];
    logic [31:0] i1_o [2];
    logic [31:0] i2_o [2];
    int n_chk = 0;
    int n_pass = 0;
    int tmo_lim [2] = '{TMO_A, TMO_B};
    int m_st [2];
    int m_tmo [2];
    logic [15:0] m_cnt [2];
    logic [15:0] m_rd [2];
    logic [2:0] m_mode [2];
    logic [31:0] m_i1 [2];
    logic [31:0] m_i2 [2];
    logic m_err [2];
    logic [31:0] osc_tab [7] = '{32'h40000000, 32'h00100000, 32'h00400000, 32'hFFC00000,
                                 32'hFF800000, 32'h007FFFFF, 32'h00800000};

    always #5 Fg_clk = ~Fg_clk;

    osc_ctrl #(.TMO_CYC(TMO_A)) u_a (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_init1(cmd_init1), .cmd_init2(cmd_init2),
        .cmd_rate_div(cmd_rate_div), .osc_out1(osc_out1), .Enable(en[0]), .Ready(rdy[0]),
        .FreqChng(fchg[0]), .Mode(mode_o[0]), .init1(i1_o[0]), .init2(i2_o[0]),
        .busy(busy[0]), .err(err[0]), .upd_done(upd[0])
    );

    osc_ctrl #(.TMO_CYC(TMO_B)) u_b (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_init1(cmd_init1), .cmd_init2(cmd_init2),
        .cmd_rate_div(cmd_rate_div), .osc_out1(osc_out1), .Enable(en[1]), .Ready(rdy[1]),
        .FreqChng(fchg[1]), .Mode(mode_o[1]), .init1(i1_o[1]), .init2(i2_o[1]),
        .busy(busy[1]), .err(err[1]), .upd_done(upd[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // sample near zero when it lies inside the signed window that the mode selects
    function automatic logic m_zc(input logic [2:0] md, input logic [31:0] v);
        int s;
        int lim;
        s = $signed(v);
        lim = (md == 3'd4) ? 8388608 : 4194304;
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic logic m_en(input int i);
        return (m_st[i] == RUN || m_st[i] == WAIT) && m_cnt[i] == m_rd[i];
    endfunction

    task automatic m_reset(input int i);
        m_st[i] = IDLE;
        m_tmo[i] = 0;
        m_cnt[i] = 16'd0;
        m_rd[i] = 16'd0;
        m_mode[i] = 3'd0;
        m_i1[i] = 32'd0;
        m_i2[i] = 32'd0;
        m_err[i] = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic ry;
            logic xe;
            ry = (m_st[i] == IDLE) || (m_st[i] == RUN);
            xe = m_en(i);
            check($sformatf("u%0d.cmd_ready", i), 32'(cmd_ready[i]), 32'(ry));
            check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(!ry));
            check($sformatf("u%0d.Enable", i), 32'(en[i]), 32'(xe));
            check($sformatf("u%0d.Ready", i), 32'(rdy[i]), 32'(m_st[i] == LOAD));
            check($sformatf("u%0d.FreqChng", i), 32'(fchg[i]), 32'(m_st[i] == CHG));
            check($sformatf("u%0d.upd_done", i), 32'(upd[i]),
                  32'(m_st[i] == WAIT && xe && m_zc(m_mode[i], osc_out1)));
            check($sformatf("u%0d.err", i), 32'(err[i]), 32'(m_err[i]));
            check($sformatf("u%0d.Mode", i), 32'(mode_o[i]), 32'(m_mode[i]));
            check($sformatf("u%0d.init1", i), i1_o[i], m_i1[i]);
            check($sformatf("u%0d.init2", i), i2_o[i], m_i2[i]);
        end
    endtask

    // advance the model by one clock using the inputs held across the edge
    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            logic xfer;
            logic ap;
            logic [15:0] nc;
            if (!Resetn) begin
                m_reset(i);
                continue;
            end
            xfer = cmd_valid && (m_st[i] == IDLE || m_st[i] == RUN);
            ap = m_st[i] == WAIT && m_en(i) && m_zc(m_mode[i], osc_out1);
            nc = (m_cnt[i] == m_rd[i]) ? 16'd0 : m_cnt[i] + 16'd1;
            if (xfer && cmd_op == 2'd0) begin
                m_mode[i] = cmd_mode;
                m_i1[i] = cmd_init1;
                m_i2[i] = cmd_init2;
                m_rd[i] = cmd_rate_div;
                m_err[i] = 1'b0;
                m_st[i] = LOAD;
            end else if (m_st[i] == LOAD) begin
                m_st[i] = RUN;
                m_cnt[i] = 16'd0;
            end else if (m_st[i] == RUN) begin
                m_cnt[i] = nc;
                if (xfer && cmd_op == 2'd2) m_st[i] = IDLE;
                else if (xfer && cmd_op == 2'd1) begin
                    m_i1[i] = cmd_init1;
                    m_i2[i] = cmd_init2;
                    m_st[i] = CHG;
                end
            end else if (m_st[i] == CHG) begin
                m_st[i] = WAIT;
                m_tmo[i] = 0;
            end else if (m_st[i] == WAIT) begin
                m_cnt[i] = nc;
                m_tmo[i]++;
                if (ap) m_st[i] = RUN;
                else if (m_tmo[i] == tmo_lim[i]) begin
                    m_err[i] = 1'b1;
                    m_st[i] = LOAD;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge Fg_clk);
        check_all();
        @(posedge Fg_clk);
        m_step();
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [2:0] md, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] rd);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mode = md;
        cmd_init1 = a;
        cmd_init2 = b;
        cmd_rate_div = rd;
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'd3;
    endtask

    task automatic async_reset();
        Resetn = 1'b0;
        #1;
        m_reset(0);
        m_reset(1);
        check_all();
    endtask

    initial begin
        int k;
        m_reset(0);
        m_reset(1);
        repeat (3) tick();
        Resetn = 1'b1;
        repeat (2) tick();
        cmd(2'd1, 3'd0, 32'h1, 32'h2, 16'd0);
        cmd(2'd2, 3'd0, 32'h1, 32'h2, 16'd0);
        repeat (2) tick();
        cmd(2'd0, 3'd1, 32'h10000000, 32'h3FF00000, 16'd0);
        repeat (6) tick();
        cmd(2'd0, 3'd2, 32'h12345678, 32'h0BADF00D, 16'd3);
        repeat (12) tick();
        osc_out1 = 32'h40000000;
        cmd(2'd1, 3'd7, 32'hAAAA5555, 32'h5555AAAA, 16'd9);
        repeat (50) tick();
        osc_out1 = 32'h00100000;
        repeat (10) tick();
        cmd(2'd0, 3'd3, 32'h0000_0001, 32'h0000_0002, 16'd1);
        repeat (4) tick();
        osc_out1 = 32'h40000000;
        cmd(2'd1, 3'd0, 32'hCAFEBABE, 32'hDEADBEEF, 16'd0);
        repeat (22) tick();
        cmd(2'd0, 3'd3, 32'h0000_0011, 32'h0000_0022, 16'd2);
        repeat (4) tick();
        osc_out1 = 32'h00400000;
        cmd(2'd0, 3'd4, 32'h4, 32'h44, 16'd1);
        repeat (3) tick();
        cmd(2'd1, 3'd0, 32'h5, 32'h55, 16'd0);
        repeat (6) tick();
        cmd(2'd0, 3'd0, 32'h6, 32'h66, 16'd1);
        repeat (3) tick();
        cmd(2'd1, 3'd0, 32'h7, 32'h77, 16'd0);
        repeat (20) tick();
        cmd(2'd2, 3'd0, 32'h0, 32'h0, 16'd0);
        repeat (3) tick();
        cmd(2'd0, 3'd5, 32'h8, 32'h88, 16'd0);
        async_reset();
        repeat (3) tick();
        Resetn = 1'b1;
        repeat (3) tick();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                tick();
                Resetn = 1'b1;
            end
            cmd_valid = $urandom_range(0, 3) == 0;
            cmd_op = 2'($urandom_range(0, 3));
            cmd_mode = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            cmd_init1 = $urandom;
            cmd_init2 = $urandom;
            cmd_rate_div = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 7);
                osc_out1 = (k == 7) ? $urandom : osc_tab[k];
            end
            tick();
        end
        cmd_valid = 1'b0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
